duty_dither_mc: RTL and testbench

- Multi-channel duty-cycle modulator.
- Each channel outputs either its input level `a` or `a+1`, so the average over one period sits between the two levels.
- The number of "+1" cycles per period equals a two-digit BCD threshold from the switches.
- Generalises the single-channel, fixed-100-step monitor:
  - parametrised channel count, data width and period;
  - glitch-free threshold update at period boundaries;
  - saturating increment;
  - front-loaded or distributed (Bresenham) dither mode;
  - enable.

---
 rtl/dither_pkg.sv | 25 ++
 rtl/dither_chan.sv | 72 +++++++
 rtl/duty_dither_mc.sv | 63 ++++++
 tb/tb_duty_dither_mc.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dither_pkg.sv
// Shared definitions for the duty-cycle dither modulator.
// Provides the dither mode codes and the BCD threshold decode helpers.
// Pure package: no ports, no state.
package dither_pkg;

  localparam int MODE_FRONT  = 0;
  localparam int MODE_SPREAD = 1;

  // True when either BCD digit is outside 0..9.
  function automatic logic bcd_invalid(input logic [7:0] bcd);
    return (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
  endfunction

  // Two-digit BCD to binary. An invalid digit means full duty. A value above
  // the period is clamped to the period.
  function automatic logic [7:0] bcd2bin(input logic [7:0] bcd, input logic [7:0] period);
    logic [7:0] bin;
    bin = ({4'd0, bcd[7:4]} * 8'd10) + {4'd0, bcd[3:0]};
    if (bcd_invalid(bcd) || (bin > period)) begin
      bin = period;
    end
    return bin;
  endfunction

endpackage

// File: rtl/dither_chan.sv
// One dither channel: BCD decode register, period-boundary threshold shadow,
// Bresenham accumulator, bump decision and registered output.
// Ports: clk/rst/en, shared step index cnt, base level a, threshold thr_bcd; outputs b, thre.
module dither_chan
  import dither_pkg::*;
#(
  parameter int W      = 2,
  parameter int PERIOD = 100,
  parameter int MODE   = 0,
  parameter int SAT    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [7:0]   cnt,
  input  logic [W-1:0] a,
  input  logic [7:0]   thr_bcd,
  output logic [W-1:0] b,
  output logic [7:0]   thre
);

  localparam logic [7:0] PER8 = 8'(PERIOD);
  localparam logic [8:0] PER9 = 9'(PERIOD);

  logic [7:0]   thr_dec;
  logic [7:0]   thr_use;
  logic [8:0]   acc;
  logic [8:0]   acc_base;
  logic [8:0]   s;
  logic         bump;
  logic [W-1:0] a_inc;

  always_comb begin
    // At step 0 the freshly decoded threshold is used directly, so the whole
    // period sees one consistent value; mid-period changes wait for step 0.
    thr_use  = (cnt == 8'd0) ? thr_dec : thre;
    acc_base = (cnt == 8'd0) ? 9'd0 : acc;
    // acc < PERIOD and thr_use <= PERIOD, so s < 510 fits in 9 bits.
    s        = acc_base + {1'b0, thr_use};
    if (MODE == MODE_SPREAD) begin
      bump = (s >= PER9);
    end else begin
      bump = (cnt < thr_use);
    end
    if ((SAT != 0) && (a == {W{1'b1}})) begin
      a_inc = a;
    end else begin
      a_inc = a + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      thr_dec <= 8'd0;
      thre    <= 8'd0;
      acc     <= 9'd0;
      b       <= '0;
    end else begin
      thr_dec <= bcd2bin(thr_bcd, PER8);
      if (en) begin
        if (cnt == 8'd0) begin
          thre <= thr_dec;
        end
        acc <= bump ? (s - PER9) : s;
        b   <= bump ? a_inc : a;
      end else begin
        b <= a;
      end
    end
  end

endmodule

// File: rtl/duty_dither_mc.sv
// Multi-channel duty-cycle modulator: each channel emits a or a+1, with the
// number of +1 steps per period set by a per-channel BCD threshold.
// Ports: clk, rst (sync, high), en, a[NCH*W], thr_bcd[NCH*8]; outputs b, cnt, thre, wrap.
module duty_dither_mc
  import dither_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int W      = 2,
  parameter int PERIOD = 100,
  parameter int MODE   = MODE_FRONT,
  parameter int SAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH*W-1:0] a,
  input  logic [NCH*8-1:0] thr_bcd,
  output logic [NCH*W-1:0] b,
  output logic [7:0]       cnt,
  output logic [NCH*8-1:0] thre,
  output logic             wrap
);

  localparam logic [7:0] LAST = 8'(PERIOD - 1);

  // Shared step counter; wrap is high in the cycle that shows step 0 after
  // a completed period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 8'd0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (en) begin
        if (cnt == LAST) begin
          cnt  <= 8'd0;
          wrap <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    dither_chan #(
      .W      (W),
      .PERIOD (PERIOD),
      .MODE   (MODE),
      .SAT    (SAT)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .cnt     (cnt),
      .a       (a[c*W +: W]),
      .thr_bcd (thr_bcd[c*8 +: 8]),
      .b       (b[c*W +: W]),
      .thre    (thre[c*8 +: 8])
    );
  end

endmodule

// File: tb/tb_duty_dither_mc.sv
// Bench for duty_dither_mc: three instances (front/sat, spread/sat, front/wrap)
// driven in parallel and compared every cycle against a behavioural model.
module tb_duty_dither_mc;

  localparam int P = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [3:0]  a = 4'd0;
  logic [15:0] thr_bcd = 16'd0;

  logic [3:0]  bq [3];
  logic [7:0]  cq [3];
  logic [15:0] tq [3];
  logic        wq [3];

  always #5 clk = ~clk;

  duty_dither_mc #(.NCH(2), .W(2), .PERIOD(P), .MODE(0), .SAT(1)) u_front (
    .clk(clk), .rst(rst), .en(en), .a(a), .thr_bcd(thr_bcd),
    .b(bq[0]), .cnt(cq[0]), .thre(tq[0]), .wrap(wq[0]));

  duty_dither_mc #(.NCH(2), .W(2), .PERIOD(P), .MODE(1), .SAT(1)) u_spread (
    .clk(clk), .rst(rst), .en(en), .a(a), .thr_bcd(thr_bcd),
    .b(bq[1]), .cnt(cq[1]), .thre(tq[1]), .wrap(wq[1]));

  duty_dither_mc #(.NCH(2), .W(2), .PERIOD(P), .MODE(0), .SAT(0)) u_wrapinc (
    .clk(clk), .rst(rst), .en(en), .a(a), .thr_bcd(thr_bcd),
    .b(bq[2]), .cnt(cq[2]), .thre(tq[2]), .wrap(wq[2]));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int m_cnt;
  int m_wrap;
  int m_dec  [2];
  int m_thre [2];
  int m_b    [3][2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int decode(input logic [7:0] bcd);
    int t, u, v;
    t = int'(bcd[7:4]);
    u = int'(bcd[3:0]);
    if (t > 9 || u > 9) return P;
    v = 10 * t + u;
    return (v > P) ? P : v;
  endfunction

  // Front mode: first t steps. Spread mode: step k bumps when the ideal
  // cumulative count floor(k*t/P) steps up between k and k+1.
  function automatic bit want_bump(input int mode, input int k, input int t);
    if (mode == 0) return k < t;
    return ((k + 1) * t) / P > (k * t) / P;
  endfunction

  function automatic int inc(input int v, input int sat);
    if (v == 3) return sat ? 3 : 0;
    return v + 1;
  endfunction

  task automatic tick();
    int t_use, av;
    bit bmp;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_wrap = 0;
      for (int c = 0; c < 2; c++) begin
        m_dec[c] = 0;
        m_thre[c] = 0;
        for (int i = 0; i < 3; i++) m_b[i][c] = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        t_use = (m_cnt == 0) ? m_dec[c] : m_thre[c];
        av = int'(a[c*2 +: 2]);
        for (int i = 0; i < 3; i++) begin
          bmp = en && want_bump((i == 1) ? 1 : 0, m_cnt, t_use);
          m_b[i][c] = bmp ? inc(av, (i == 2) ? 0 : 1) : av;
        end
        if (en && m_cnt == 0) m_thre[c] = m_dec[c];
        m_dec[c] = decode(thr_bcd[c*8 +: 8]);
      end
      m_wrap = en && (m_cnt == P - 1);
      if (en) m_cnt = (m_cnt == P - 1) ? 0 : m_cnt + 1;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cnt[%0d]", i), 32'(cq[i]), 32'(m_cnt));
      check($sformatf("wrap[%0d]", i), 32'(wq[i]), 32'(m_wrap));
      for (int c = 0; c < 2; c++) begin
        check($sformatf("thre[%0d][%0d]", i, c), 32'(tq[i][c*8 +: 8]), 32'(m_thre[c]));
        check($sformatf("b[%0d][%0d] step %0d", i, c, m_cnt), 32'(bq[i][c*2 +: 2]), 32'(m_b[i][c]));
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the model step index equals k (bounded).
  task automatic run_to(input int k);
    int guard;
    guard = 0;
    while (m_cnt != k && guard < 3 * P) begin
      tick();
      guard++;
    end
    check("run_to_reached", 32'(m_cnt), 32'(k));
  endtask

  initial begin
    m_cnt = 0;
    m_wrap = 0;
    for (int c = 0; c < 2; c++) begin
      m_dec[c] = 0;
      m_thre[c] = 0;
      for (int i = 0; i < 3; i++) m_b[i][c] = 0;
    end

    // Reset with a = 3 on both channels
    rst = 1'b1; en = 1'b1; a = 4'b1111; thr_bcd = 16'h9999;
    run(3);
    rst = 1'b0;

    // ch0 thr 25, a=1; ch1 invalid BCD, a=3
    a = {2'd3, 2'd1};
    thr_bcd = {8'h3A, 8'h25};
    run(2 * P + 5);

    // Mid-period threshold change at step 40
    thr_bcd = {8'h99, 8'h10};
    run_to(0);
    run_to(40);
    thr_bcd = {8'h00, 8'h50};
    run(P + 70);

    // Zero bumps, 99 bumps, a = 0
    a = 4'd0;
    thr_bcd = {8'h00, 8'h99};
    run_to(0);
    run(P + 10);
    thr_bcd = {8'h99, 8'h25};
    run_to(0);
    run(P);

    // Enable gap at step 60, then reset at step 70
    run_to(60);
    en = 1'b0;
    a = 4'b1001;
    run(10);
    en = 1'b1;
    a = 4'd0;
    run_to(70);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(20);

    // Randomized phase
    for (int i = 0; i < 900; i++) begin
      a = 4'($urandom);
      en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) thr_bcd = 16'($urandom);
      else if ($urandom_range(0, 79) == 0)
        thr_bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                   4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      tick();
    end
    rst = 1'b0;
    en = 1'b1;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
